// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared constants and state type for the RSA datapath blocks
//
// Contents:
//   DATA_LENGTH  modulus length in bits
//   DATA_WIDTH   word width of the limb datapath
//   WIDTH        divider operand/result width (one guard bit above DATA_LENGTH)
//   arb_state_t  state encoding of the divider-sharing arbiter
package rsa_pkg;

  localparam int DATA_LENGTH = 1024;
  localparam int DATA_WIDTH  = 64;
  localparam int WIDTH       = DATA_LENGTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of one requester
//
// Ports:
//   req  in   N      request levels
//   ptr  in   PTR_W  highest-priority slot for this pick
//   gnt  out  N      one-hot winner (all zero when req is zero)
//   idx  out  PTR_W  binary index of the winner (zero when req is zero)
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  // One guard bit so ptr + offset can exceed N before wrapping.
  logic [PTR_W:0] slot;
  logic           found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    slot  = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (slot >= (PTR_W + 1)'(N)) begin
        slot = slot - (PTR_W + 1)'(N);
      end
      if (!found && req[slot[PTR_W-1:0]]) begin
        found                 = 1'b1;
        gnt[slot[PTR_W-1:0]]  = 1'b1;
        idx                   = slot[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rsa_div_arbiter.sv
// rtl/rsa_div_arbiter.sv - round-robin sharing of one divider among NUM_REQ requesters
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req             per-requester request level, sampled only while idle
//   req_dividend    flattened dividends, slot i at [i*WIDTH +: WIDTH]
//   req_divisor     flattened divisors, same packing
//   grant           one-hot pulse: operands of that slot were captured
//   rsp_valid       one-hot pulse: result for that slot is on rsp_*
//   rsp_quot/rem    result, held until the next response
//   rsp_err         set for divide-by-zero or divider timeout
//   div_start       start pulse to the shared divider
//   div_q/div_m     registered dividend/divisor, held while the divider runs
//   div_q_out/div_r divider quotient/remainder
//   div_done        divider completion pulse
//   busy            high whenever a job is in flight
//   timeout_flag    sticky record that the divider ever timed out
module rsa_div_arbiter #(
  parameter int WIDTH   = rsa_pkg::WIDTH,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 2100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_quot,
  output logic [WIDTH-1:0]         rsp_rem,
  output logic                     rsp_err,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_q,
  output logic [WIDTH-1:0]         div_m,
  input  logic [WIDTH-1:0]         div_q_out,
  input  logic [WIDTH-1:0]         div_r,
  input  logic                     div_done,
  output logic                     busy,
  output logic                     timeout_flag
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  rsa_pkg::arb_state_t state;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [CNT_W-1:0]   wait_cnt;

  logic [WIDTH-1:0] dividend_arr [NUM_REQ];
  logic [WIDTH-1:0] divisor_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dividend_arr[g] = req_dividend[g*WIDTH +: WIDTH];
    assign divisor_arr[g]  = req_divisor[g*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign busy = (state != rsa_pkg::IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= rsa_pkg::IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      wait_cnt     <= '0;
      grant        <= '0;
      rsp_valid    <= '0;
      rsp_quot     <= '0;
      rsp_rem      <= '0;
      rsp_err      <= 1'b0;
      div_start    <= 1'b0;
      div_q        <= '0;
      div_m        <= '0;
      timeout_flag <= 1'b0;
    end else begin
      // Pulse outputs fall back to zero unless a state below raises them.
      grant     <= '0;
      rsp_valid <= '0;
      div_start <= 1'b0;

      case (state)
        rsa_pkg::IDLE: begin
          if (|req) begin
            grant  <= pick_gnt;
            div_q  <= dividend_arr[pick_idx];
            div_m  <= divisor_arr[pick_idx];
            owner  <= pick_idx;
            rr_ptr <= (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            if (divisor_arr[pick_idx] == '0) begin
              // Answer divide-by-zero locally; the divider is never started.
              rsp_quot <= '1;
              rsp_rem  <= dividend_arr[pick_idx];
              rsp_err  <= 1'b1;
              state    <= rsa_pkg::RESP;
            end else begin
              state <= rsa_pkg::START;
            end
          end
        end

        rsa_pkg::START: begin
          div_start <= 1'b1;
          wait_cnt  <= '0;
          state     <= rsa_pkg::WAIT;
        end

        rsa_pkg::WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (div_done) begin
            rsp_quot <= div_q_out;
            rsp_rem  <= div_r;
            rsp_err  <= 1'b0;
            state    <= rsa_pkg::RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_quot     <= '0;
            rsp_rem      <= '0;
            rsp_err      <= 1'b1;
            timeout_flag <= 1'b1;
            state        <= rsa_pkg::RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        rsa_pkg::RESP: begin
          rsp_valid <= NUM_REQ'(1) << owner;
          state     <= rsa_pkg::IDLE;
        end

        default: state <= rsa_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_div_arbiter.sv
// tb/tb_rsa_div_arbiter.sv - self-checking bench for rsa_div_arbiter
module tb_rsa_div_arbiter;

  localparam int WIDTH   = 1025;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 2100;
  localparam int PW      = $clog2(NUM_REQ);

  typedef logic [WIDTH-1:0] wide_t;

  typedef struct {
    logic [NUM_REQ-1:0] vld;
    wide_t              quot;
    wide_t              rem;
    logic               err;
  } rsp_t;

  typedef struct {
    logic [PW-1:0] slot;
    wide_t         dvd;
    wide_t         dvs;
    int            dly;
    wide_t         quot;
    wide_t         rem;
    logic          err;
  } vec_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       rsp_valid;
  wide_t                    rsp_quot;
  wide_t                    rsp_rem;
  logic                     rsp_err;
  logic                     div_start;
  wide_t                    div_q;
  wide_t                    div_m;
  wide_t                    div_q_out;
  wide_t                    div_r;
  logic                     div_done;
  logic                     busy;
  logic                     timeout_flag;

  wide_t dvd_arr [NUM_REQ];
  wide_t dvs_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_dividend[g*WIDTH +: WIDTH] = dvd_arr[g];
    assign req_divisor[g*WIDTH +: WIDTH]  = dvs_arr[g];
  end

  rsa_div_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .grant        (grant),
    .rsp_valid    (rsp_valid),
    .rsp_quot     (rsp_quot),
    .rsp_rem      (rsp_rem),
    .rsp_err      (rsp_err),
    .div_start    (div_start),
    .div_q        (div_q),
    .div_m        (div_m),
    .div_q_out    (div_q_out),
    .div_r        (div_r),
    .div_done     (div_done),
    .busy         (busy),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk_n(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got [127:0]=%h, expected [127:0]=%h", name, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] s);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Divider model: answers div_q/div_m model_dly falling edges after it sees div_start.
  int    model_dly = 0;
  bit    model_never = 1'b0;
  bit    model_active = 1'b0;
  int    model_cnt = 0;
  logic  model_done = 1'b0;
  logic  inject_done = 1'b0;
  assign div_done = model_done | inject_done;

  always @(negedge clk) begin
    model_done = 1'b0;
    if (!rst_n) begin
      model_active = 1'b0;
    end else begin
      if (div_start && !model_never) begin
        model_active = 1'b1;
        model_cnt    = model_dly;
      end
      if (model_active) begin
        if (model_cnt == 0) begin
          model_done   = 1'b1;
          div_q_out    = div_q / div_m;
          div_r        = div_q % div_m;
          model_active = 1'b0;
        end else begin
          model_cnt--;
        end
      end
    end
  end

  // Scoreboard and event monitor.
  rsp_t               sb[$];
  logic [NUM_REQ-1:0] grant_log[$];
  int                 n_start = 0;
  int                 n_rsp = 0;
  int                 last_start_cyc = 0;
  int                 last_rsp_cyc = 0;
  rsp_t               mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (div_start) begin
        n_start++;
        last_start_cyc = cyc;
      end
      if (grant != '0) grant_log.push_back(grant);
      if (rsp_valid != '0) begin
        n_rsp++;
        last_rsp_cyc = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b, expected no response", rsp_valid);
        end else begin
          mon_e = sb.pop_front();
          chk_n("rsp_slot", 32'(rsp_valid), 32'(mon_e.vld));
          chk_w("rsp_quot", rsp_quot, mon_e.quot);
          chk_w("rsp_rem", rsp_rem, mon_e.rem);
          chk_n("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk_n("job_drained_in_budget", 32'(sb.size()), 32'(0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk_n({tag, "_busy"}, 32'(busy), 32'(0));
    chk_n({tag, "_grant"}, 32'(grant), 32'(0));
    chk_n({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk_n({tag, "_div_start"}, 32'(div_start), 32'(0));
    chk_n({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
    chk_n({tag, "_timeout_flag"}, 32'(timeout_flag), 32'(0));
    chk_w({tag, "_div_q"}, div_q, '0);
    chk_w({tag, "_div_m"}, div_m, '0);
    chk_w({tag, "_rsp_quot"}, rsp_quot, '0);
    chk_w({tag, "_rsp_rem"}, rsp_rem, '0);
  endtask

  task automatic do_job(input vec_t v);
    rsp_t e;
    @(negedge clk);
    model_dly        = v.dly;
    dvd_arr[v.slot]  = v.dvd;
    dvs_arr[v.slot]  = v.dvs;
    req              = '0;
    req[v.slot]      = 1'b1;
    e.vld            = onehot(v.slot);
    e.quot           = v.quot;
    e.rem            = v.rem;
    e.err            = v.err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk_n("grant_after_req_edge", 32'(grant), 32'(e.vld));
    chk_n("no_start_with_grant", 32'(div_start), 32'(0));
    @(negedge clk);
    req = '0;
    @(posedge clk);
    #1;
    chk_n("grant_one_cycle", 32'(grant), 32'(0));
    chk_w("div_q_latched", div_q, v.dvd);
    chk_w("div_m_latched", div_m, v.dvs);
    if (v.dvs == '0) begin
      chk_n("div0_rsp_two_cycles", 32'(rsp_valid), 32'(e.vld));
      chk_n("div0_no_start", 32'(div_start), 32'(0));
    end else begin
      chk_n("div_start_pulse", 32'(div_start), 32'(1));
    end
    wait_done(TIMEOUT + 50);
    if (v.dvs != '0) begin
      if (v.err) chk_n("timeout_latency", 32'(last_rsp_cyc - last_start_cyc), 32'(TIMEOUT + 1));
      else       chk_n("done_latency", 32'(last_rsp_cyc - last_start_cyc), 32'(v.dly + 2));
    end
  endtask

  function automatic vec_t mk(input logic [PW-1:0] s, input wide_t a, input wide_t b, input int d,
                              input wide_t q, input wide_t r, input logic e);
    vec_t v;
    v.slot = s; v.dvd = a; v.dvs = b; v.dly = d; v.quot = q; v.rem = r; v.err = e;
    return v;
  endfunction

  vec_t vecs[8];
  logic [NUM_REQ-1:0] exp_order[4];

  initial begin
    int g0, g1, n, s0, r0;

    vecs[0] = mk(1'b0, wide_t'(1) << 64, wide_t'(15), 10, wide_t'(64'h1111111111111111), wide_t'(1), 1'b0);
    vecs[1] = mk(1'b1, wide_t'(100), wide_t'(7), 3, wide_t'(14), wide_t'(2), 1'b0);
    vecs[2] = mk(1'b1, wide_t'(16'h1234), '0, 0, '1, wide_t'(16'h1234), 1'b1);
    vecs[3] = mk(1'b0, wide_t'(1) << 1024, wide_t'(2), 0, wide_t'(1) << 1023, '0, 1'b0);
    vecs[4] = mk(1'b1, '1, '1, 1, wide_t'(1), '0, 1'b0);
    vecs[5] = mk(1'b0, wide_t'(16'hABCD), '0, 0, '1, wide_t'(16'hABCD), 1'b1);
    vecs[6] = mk(1'b0, wide_t'(50), wide_t'(6), TIMEOUT - 1, wide_t'(8), wide_t'(2), 1'b0);
    vecs[7] = mk(1'b1, wide_t'(77), wide_t'(5), TIMEOUT, '0, '0, 1'b1);

    exp_order[0] = 2'b01;
    exp_order[1] = 2'b10;
    exp_order[2] = 2'b01;
    exp_order[3] = 2'b10;

    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dvd_arr[i] = '0;
      dvs_arr[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: both requesters hold req for two jobs each.
    @(negedge clk);
    model_dly  = 5;
    dvd_arr[0] = wide_t'(100);
    dvs_arr[0] = wide_t'(7);
    dvd_arr[1] = wide_t'(1000);
    dvs_arr[1] = wide_t'(3);
    for (int j = 0; j < 2; j++) begin
      sb.push_back('{vld: 2'b01, quot: wide_t'(14), rem: wide_t'(2), err: 1'b0});
      sb.push_back('{vld: 2'b10, quot: wide_t'(333), rem: wide_t'(1), err: 1'b0});
    end
    grant_log.delete();
    s0  = n_start;
    req = 2'b11;
    g0  = 0;
    g1  = 0;
    n   = 0;
    while ((g0 < 2 || g1 < 2) && n < 400) begin
      @(negedge clk);
      n++;
      if (grant[0]) begin g0++; if (g0 == 2) req[0] = 1'b0; end
      if (grant[1]) begin g1++; if (g1 == 2) req[1] = 1'b0; end
    end
    req = '0;
    wait_done(400);
    chk_n("contention_grant_count", 32'(grant_log.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > i) chk_n("contention_grant_order", 32'(grant_log[i]), 32'(exp_order[i]));
    end
    chk_n("contention_start_count", 32'(n_start - s0), 32'(4));

    // Table of single jobs up to and including the done/timeout collision.
    for (int i = 0; i < 7; i++) do_job(vecs[i]);
    chk_n("collision_no_timeout_flag", 32'(timeout_flag), 32'(0));

    // Done arrives one cycle too late: timeout, and the late done lands in RESP.
    r0 = n_rsp;
    do_job(vecs[7]);
    repeat (4) @(negedge clk);
    chk_n("late_done_single_rsp", 32'(n_rsp - r0), 32'(1));
    chk_n("timeout_flag_set", 32'(timeout_flag), 32'(1));

    // Divider that never answers, followed by a stray done while idle.
    model_never = 1'b1;
    do_job(mk(1'b0, wide_t'(5), wide_t'(3), 0, '0, '0, 1'b1));
    r0 = n_rsp;
    @(negedge clk);
    inject_done = 1'b1;
    @(negedge clk);
    inject_done = 1'b0;
    repeat (5) @(negedge clk);
    chk_n("idle_done_ignored", 32'(n_rsp - r0), 32'(0));
    chk_n("idle_done_not_busy", 32'(busy), 32'(0));
    chk_n("timeout_flag_sticky", 32'(timeout_flag), 32'(1));

    // Reset while the divider is running.
    @(negedge clk);
    dvd_arr[0] = wide_t'(9);
    dvs_arr[0] = wide_t'(4);
    req        = 2'b01;
    @(negedge clk);
    req = '0;
    repeat (20) @(posedge clk);
    chk_n("busy_before_reset", 32'(busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    model_never = 1'b0;
    do_job(mk(1'b1, wide_t'(12), wide_t'(5), 4, wide_t'(2), wide_t'(2), 1'b0));
    chk_n("flag_clear_after_reset", 32'(timeout_flag), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, expected finish before 600000 time units");
    $fatal(1);
  end

endmodule
